loss_accumulator: RTL and testbench
===================================

LOSS_ACCUMULATOR -- requirements
Module: loss_accumulator

Interface
REQ-001 Parameter LANES, default 4: elements per beat; valid range 1..16.
REQ-002 Parameter DATA_W, default 32: signed width of each data and target element; valid range 4..32.
REQ-003 Parameter ACC_W, default 72: frame accumulator width; SHALL be >= 2*DATA_W+2+clog2(LANES), and elaboration fails otherwise.
REQ-004 Parameter CNT_W, default 16: element-count width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts a beat; a beat transfers when in_valid && in_ready.
REQ-009 data_in  in  LANES*DATA_W  signed elements; lane i at bits [i*DATA_W +: DATA_W].
REQ-010 target_in  in  LANES*DATA_W  signed targets, same packing as data_in.
REQ-011 lane_en_in  in  LANES  per-lane enable; 0 = lane excluded from this beat.
REQ-012 last_in  in  1  beat is the final beat of the frame.
REQ-013 mode_in  in  1  0 = L1 |d-t|, 1 = L2 (d-t)^2; sampled on the first beat of a frame only.
REQ-014 elem_valid  out  1  per-element loss valid.
REQ-015 elem_loss  out  LANES*(2*DATA_W+2)  unsigned per-lane loss, zero-extended.
REQ-016 sum_valid  out  1  frame result valid.
REQ-017 sum_ready  in  1  consumer accepts the frame result.
REQ-018 sum_out  out  ACC_W  unsigned frame loss sum.
REQ-019 count_out  out  CNT_W  number of enabled elements in the frame, saturating at 2^CNT_W-1.
REQ-020 sat_out  out  1  sticky flag: sum_out saturated during the frame.

Function
REQ-021 Difference computed at DATA_W+1 bits: no wrap.
  - L1 loss: |diff|.
  - L2 loss: diff*diff, exact in 2*DATA_W+2 bits.
  - A disabled lane yields 0.
REQ-022 Beat accepted in cycle t: elem_valid=1 and elem_loss valid in cycle t+1. elem_valid=0 in every cycle with no accepted beat; elem_loss holds its last value.
REQ-023 FSM states:
  - IDLE: accumulator, count and sat cleared.
  - ACCUM: frame in progress.
  - DRAIN: one cycle after the last beat.
  - HOLD: result presented.
REQ-024 in_ready=1 only in IDLE and ACCUM.
REQ-025 Transitions:
  - IDLE, accepted beat with last_in=0 -> ACCUM; mode_in latched.
  - IDLE, accepted beat with last_in=1 -> DRAIN; mode_in latched; single-beat frame.
  - ACCUM, accepted beat with last_in=1 -> DRAIN.
  - DRAIN -> HOLD, unconditionally.
  - HOLD with sum_ready=1 -> IDLE.
  - All other cases: state held.
REQ-026 In ACCUM, mode_in is ignored; the latched mode applies to every beat of the frame.
REQ-027 The accumulator adds the sum of the registered lane losses one cycle after elem_valid.
  - If the add would exceed 2^ACC_W-1, the accumulator clamps to 2^ACC_W-1 and sat_out=1 until the frame result is accepted.
REQ-028 count_out increments by popcount(lane_en_in) per accepted beat and clamps at 2^CNT_W-1.
REQ-029 Last beat accepted in cycle t: sum_valid=1 from cycle t+2.
  - sum_out, count_out and sat_out are stable while sum_valid=1 and sum_ready=0.
REQ-030 sum_valid drops in the cycle after the handshake. The next beat is accepted no earlier than that same cycle, since in_ready=1 in IDLE. The accumulator starts from 0.
REQ-031 A frame with all lanes disabled completes normally: sum_out=0, count_out=0.
REQ-032 in_valid=0 in ACCUM stalls the frame indefinitely with no change to the accumulator.

Reset
REQ-033 reset=1 immediately, without waiting for a clock edge:
  - state -> IDLE.
  - in_ready=0 while reset is held.
  - elem_valid, sum_valid and sat_out = 0.
  - elem_loss, sum_out and count_out = 0.
  - latched mode = L1.
REQ-034 Reset asserted mid-frame or in HOLD discards the partial or pending result. The first beat after deassertion starts a fresh frame.

Verification (LANES=4, DATA_W=8, ACC_W=20 unless stated)
REQ-035 L1, single beat, all lanes enabled, last=1: data {10,-5,0,127}, target {3,5,0,-128} -> elem_loss {7,10,0,255} at t+1; sum_out=272, count_out=4, sat_out=0 at t+2.
REQ-036 Same beat with mode=1 -> elem_loss {49,100,0,65025}; sum_out=65174.
REQ-037 Three-beat frame, lane_en={1,1,0,0} on each beat, mode_in toggled on beats 2 and 3 -> L1 mode kept for the whole frame; count_out=6.
REQ-038 ACC_W=16 (bench override of the REQ-003 constraint), L2, two beats of {127 vs -128} on all lanes -> sum_out=65535, sat_out=1.
REQ-039 Backpressure: sum_ready held 0 for 5 cycles after sum_valid -> outputs stable and in_ready=0 throughout; a new frame is accepted only after the sum_ready handshake.
REQ-040 Reset asserted asynchronously between two clock edges in ACCUM -> outputs 0 before the next edge. A subsequent one-beat frame {1,1,1,1} vs {0,0,0,0} in L1 gives sum_out=4.

Source files
------------

// File: rtl/loss_accumulator_if.sv
// Beat stream, per-element loss and frame result signals of the loss accumulator.
// The master side produces beats and consumes results; the slave side is the accumulator.
interface loss_accumulator_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 72,
    parameter int CNT_W  = 16
);
    localparam int LOSS_W = 2 * DATA_W + 2;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   data_in;
    logic [LANES*DATA_W-1:0]   target_in;
    logic [LANES-1:0]          lane_en_in;
    logic                      last_in;
    logic                      mode_in;
    logic                      elem_valid;
    logic [LANES*LOSS_W-1:0]   elem_loss;
    logic                      sum_valid;
    logic                      sum_ready;
    logic [ACC_W-1:0]          sum_out;
    logic [CNT_W-1:0]          count_out;
    logic                      sat_out;

    modport master (
        output in_valid, data_in, target_in, lane_en_in, last_in, mode_in, sum_ready,
        input  in_ready, elem_valid, elem_loss, sum_valid, sum_out, count_out, sat_out
    );

    modport slave (
        input  in_valid, data_in, target_in, lane_en_in, last_in, mode_in, sum_ready,
        output in_ready, elem_valid, elem_loss, sum_valid, sum_out, count_out, sat_out
    );
endinterface

// File: rtl/loss_accumulator.sv
// Per-lane L1/L2 loss of data vs target, accumulated over a frame with saturation,
// element counting and a held frame result released by a ready/valid handshake.
module loss_accumulator #(
    parameter int LANES       = 4,
    parameter int DATA_W      = 32,
    parameter int ACC_W       = 72,
    parameter int CNT_W       = 16,
    parameter bit CHECK_ACC_W = 1'b1
) (
    input logic               clk,
    input logic               reset,
    loss_accumulator_if.slave bus
);
    localparam int LOSS_W = 2 * DATA_W + 2;
    localparam int DIFF_W = DATA_W + 1;
    localparam int SUM_W  = LOSS_W + $clog2(LANES) + 1;
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int POP_W  = $clog2(LANES + 1);
    localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({ACC_W{1'b1}});

    if ((CHECK_ACC_W && (ACC_W < 2 * DATA_W + 2 + $clog2(LANES))) ||
        LANES < 1 || LANES > 16 || DATA_W < 4 || DATA_W > 32) begin : g_param_check
        $error("loss_accumulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                        state_q, state_d;
    logic                          in_ready, accept, handshake, eff_mode;
    logic                          mode_q;
    logic                          elem_valid_q;
    logic [LANES-1:0][LOSS_W-1:0]  lane_loss;
    logic [LANES-1:0][LOSS_W-1:0]  elem_loss_q;
    logic [SUM_W-1:0]              beat_sum;
    logic [EXT_W-1:0]              acc_sum;
    logic [ACC_W-1:0]              acc_q;
    logic                          sat_q;
    logic [POP_W-1:0]              pop;
    logic [CNT_W-1:0]              count_q, cnt_base, cnt_next;
    logic [CNT_W:0]                cnt_sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = !reset;
                if (bus.in_valid && in_ready) state_d = bus.last_in ? DRAIN : ACCUM;
            end
            ACCUM: begin
                in_ready = !reset;
                if (bus.in_valid && in_ready && bus.last_in) state_d = DRAIN;
            end
            DRAIN:   state_d = HOLD;
            HOLD:    if (bus.sum_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept    = bus.in_valid && in_ready;
    assign handshake = (state_q == HOLD) && bus.sum_ready;
    // The first beat of a frame uses mode_in directly; later beats use the latched copy.
    assign eff_mode  = (state_q == IDLE) ? bus.mode_in : mode_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] d, t;
        logic [DIFF_W-1:0] diff, mag;
        logic [LOSS_W-1:0] sq;
        assign d    = bus.data_in[i*DATA_W +: DATA_W];
        assign t    = bus.target_in[i*DATA_W +: DATA_W];
        assign diff = {d[DATA_W-1], d} - {t[DATA_W-1], t};
        assign mag  = diff[DIFF_W-1] ? (DIFF_W'(0) - diff) : diff;
        assign sq   = LOSS_W'(mag) * LOSS_W'(mag);
        assign lane_loss[i] = bus.lane_en_in[i] ? (eff_mode ? sq : LOSS_W'(mag)) : '0;
    end

    always_comb begin
        pop      = '0;
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            pop      = pop + POP_W'(bus.lane_en_in[i]);
            beat_sum = beat_sum + SUM_W'(elem_loss_q[i]);
        end
    end

    assign acc_sum  = EXT_W'(acc_q) + EXT_W'(beat_sum);
    assign cnt_base = (state_q == IDLE) ? '0 : count_q;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(pop);
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // the loss register is reset too because it drives a visible output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            elem_valid_q <= 1'b0;
            elem_loss_q  <= '0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            elem_valid_q <= accept;
            if (accept) elem_loss_q <= lane_loss;
            if (accept && state_q == IDLE) mode_q <= bus.mode_in;

            if (state_q == IDLE || handshake) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (elem_valid_q) begin
                if (acc_sum > ACC_MAX) begin
                    acc_q <= '1;
                    sat_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum[ACC_W-1:0];
                end
            end

            if (accept) count_q <= cnt_next;
            else if (state_q == IDLE || handshake) count_q <= '0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.elem_valid = elem_valid_q;
    assign bus.elem_loss  = elem_loss_q;
    assign bus.sum_valid  = (state_q == HOLD);
    assign bus.sum_out    = acc_q;
    assign bus.count_out  = count_q;
    assign bus.sat_out    = sat_q;
endmodule

// File: tb/tb_loss_accumulator.sv
// Randomized bench for loss_accumulator: two instances (20-bit and 16-bit accumulators)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_loss_accumulator;
    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int ACC_A  = 20;
    localparam int ACC_B  = 16;
    localparam int LOSS_W = 2 * DATA_W + 2;
    localparam longint MAX_A   = (longint'(1) << ACC_A) - 1;
    localparam longint MAX_B   = (longint'(1) << ACC_B) - 1;
    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, last_in = 1'b0, mode_in = 1'b0, sum_ready = 1'b0;
    logic [LANES*DATA_W-1:0] data_in = '0, target_in = '0;
    logic [LANES-1:0] lane_en_in = '0;

    loss_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) ifa ();
    loss_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_B), .CNT_W(CNT_W)) ifb ();

    assign ifa.in_valid = in_valid;    assign ifb.in_valid = in_valid;
    assign ifa.data_in = data_in;      assign ifb.data_in = data_in;
    assign ifa.target_in = target_in;  assign ifb.target_in = target_in;
    assign ifa.lane_en_in = lane_en_in; assign ifb.lane_en_in = lane_en_in;
    assign ifa.last_in = last_in;      assign ifb.last_in = last_in;
    assign ifa.mode_in = mode_in;      assign ifb.mode_in = mode_in;
    assign ifa.sum_ready = sum_ready;  assign ifb.sum_ready = sum_ready;

    loss_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    loss_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_B), .CNT_W(CNT_W),
                       .CHECK_ACC_W(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Frame description and reference model state.
    int  bd[16][4];
    int  bt[16][4];
    bit  ben[16][4];
    bit  bm[16];
    int  nbeats;
    longint sum_a, sum_b, cnt;
    bit  sat_a, sat_b, fmode;
    logic [LANES*LOSS_W-1:0] exp_q[$];
    bit  pend = 1'b0;

    function automatic longint lane_loss_ref(int d, int t, bit en, bit m);
        longint df = longint'(d) - longint'(t);
        if (!en) return 0;
        if (m) return df * df;
        return (df < 0) ? -df : df;
    endfunction

    function automatic void start_frame();
        sum_a = 0; sum_b = 0; sat_a = 0; sat_b = 0; cnt = 0; fmode = bm[0];
    endfunction

    function automatic int rand_elem();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) != 0) ? 127 : -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic void fill_random(int n, bit m, bit toggle);
        nbeats = n;
        for (int b = 0; b < n; b++) begin
            bm[b] = toggle ? 1'($urandom_range(0, 1)) : m;
            for (int i = 0; i < LANES; i++) begin
                bd[b][i]  = rand_elem();
                bt[b][i]  = rand_elem();
                ben[b][i] = ($urandom_range(0, 3) != 0);
            end
        end
    endfunction

    // Elements are checked one cycle after each accepted beat, in beat order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            check("elem_valid_a", ifa.elem_valid, pend);
            check("elem_valid_b", ifb.elem_valid, pend);
            if (pend && exp_q.size() > 0) begin
                logic [LANES*LOSS_W-1:0] e;
                e = exp_q.pop_front();
                check("elem_loss_a", ifa.elem_loss, e);
                check("elem_loss_b", ifb.elem_loss, e);
            end
            pend = in_valid && ifa.in_ready;
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepts the beat.
    task automatic send_beat(input int b, input bit last);
        logic [LANES*LOSS_W-1:0] e;
        longint bs;
        e = '0;
        bs = 0;
        in_valid = 1'b1;
        last_in  = last;
        mode_in  = bm[b];
        for (int i = 0; i < LANES; i++) begin
            longint l;
            data_in[i*DATA_W +: DATA_W]   = DATA_W'(bd[b][i]);
            target_in[i*DATA_W +: DATA_W] = DATA_W'(bt[b][i]);
            lane_en_in[i] = ben[b][i];
            l = lane_loss_ref(bd[b][i], bt[b][i], ben[b][i], fmode);
            e[i*LOSS_W +: LOSS_W] = LOSS_W'(l);
            bs += l;
            if (ben[b][i]) cnt++;
        end
        if (cnt > MAX_CNT) cnt = MAX_CNT;
        exp_q.push_back(e);
        if (sum_a + bs > MAX_A) begin sum_a = MAX_A; sat_a = 1'b1; end else sum_a += bs;
        if (sum_b + bs > MAX_B) begin sum_b = MAX_B; sat_b = 1'b1; end else sum_b += bs;
        @(negedge clk);
        check("in_ready_a", ifa.in_ready, 1);
        check("in_ready_b", ifb.in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic run_frame(input int bp, input bit stalls);
        start_frame();
        for (int b = 0; b < nbeats; b++) begin
            if (stalls) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    mode_in  = 1'($urandom_range(0, 1));
                    data_in  = $urandom;
                    @(posedge clk); #1;
                end
            end
            send_beat(b, b == nbeats - 1);
        end
        in_valid = 1'($urandom_range(0, 1));
        data_in  = $urandom;
        @(negedge clk);
        check("drain_in_ready", ifa.in_ready, 0);
        check("drain_sum_valid", ifa.sum_valid, 0);
        @(posedge clk); #1;
        for (int k = 0; k <= bp; k++) begin
            sum_ready = (k == bp);
            in_valid  = 1'($urandom_range(0, 1));
            data_in   = $urandom;
            @(negedge clk);
            check("hold_sum_valid_a", ifa.sum_valid, 1);
            check("hold_sum_valid_b", ifb.sum_valid, 1);
            check("hold_in_ready_a", ifa.in_ready, 0);
            check("hold_in_ready_b", ifb.in_ready, 0);
            check("sum_out_a", ifa.sum_out, sum_a);
            check("sum_out_b", ifb.sum_out, sum_b);
            check("count_out_a", ifa.count_out, cnt);
            check("count_out_b", ifb.count_out, cnt);
            check("sat_out_a", ifa.sat_out, sat_a);
            check("sat_out_b", ifb.sat_out, sat_b);
            @(posedge clk); #1;
        end
        sum_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("idle_sum_valid", ifa.sum_valid, 0);
        check("idle_in_ready", ifa.in_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready", ifa.in_ready, 0);
        check("rst_elem_valid", ifa.elem_valid, 0);
        check("rst_sum_valid", ifa.sum_valid, 0);
        check("rst_sat_out", ifa.sat_out, 0);
        check("rst_elem_loss", ifa.elem_loss, 0);
        check("rst_sum_out", ifa.sum_out, 0);
        check("rst_count_out", ifa.count_out, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;

        // L1 and L2 single-beat frames with known values.
        nbeats = 1;
        bd[0] = '{10, -5, 0, 127};
        bt[0] = '{3, 5, 0, -128};
        ben[0] = '{1, 1, 1, 1};
        bm[0] = 1'b0;
        run_frame(0, 1'b0);
        bm[0] = 1'b1;
        run_frame(0, 1'b0);

        // Mode toggled after the first beat must be ignored.
        fill_random(3, 1'b0, 1'b0);
        bm[1] = 1'b1; bm[2] = 1'b1;
        for (int b = 0; b < 3; b++) ben[b] = '{1, 1, 0, 0};
        run_frame(0, 1'b0);

        // Saturation of the narrow accumulator.
        nbeats = 2;
        for (int b = 0; b < 2; b++) begin
            bd[b] = '{127, 127, 127, 127};
            bt[b] = '{-128, -128, -128, -128};
            ben[b] = '{1, 1, 1, 1};
            bm[b] = 1'b1;
        end
        run_frame(0, 1'b0);

        // Backpressure on the result, then an all-disabled frame.
        fill_random(3, 1'b1, 1'b0);
        run_frame(5, 1'b1);
        fill_random(2, 1'b0, 1'b0);
        for (int b = 0; b < 2; b++) ben[b] = '{0, 0, 0, 0};
        run_frame(1, 1'b0);

        // Reset in the middle of a frame discards it.
        fill_random(2, 1'b0, 1'b0);
        start_frame();
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_in_ready", ifa.in_ready, 0);
        check("mid_rst_elem_valid", ifa.elem_valid, 0);
        check("mid_rst_elem_loss", ifa.elem_loss, 0);
        check("mid_rst_sum_out", ifa.sum_out, 0);
        check("mid_rst_count_out", ifa.count_out, 0);
        check("mid_rst_sat_out", ifb.sat_out, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        nbeats = 1;
        bd[0] = '{1, 1, 1, 1};
        bt[0] = '{0, 0, 0, 0};
        ben[0] = '{1, 1, 1, 1};
        bm[0] = 1'b0;
        run_frame(0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            fill_random(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_frame(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
